// File: rtl/csa_accum_pkg.sv
// Shared types and default sizing for the carry-save accumulator.
package csa_accum_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GUARD = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

endpackage

// File: rtl/csa_accum_csa_row.sv
// Purely combinational 3:2 compressor row: bitwise sum and unshifted majority.
module csa_row #(
  parameter int W = 36
) (
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] c_in,
  output logic [W-1:0] sum_out,
  output logic [W-1:0] maj_out
);

  always_comb begin
    sum_out = a_in ^ b_in ^ c_in;
    maj_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
  end

endmodule

// File: rtl/csa_accum.sv
// Streaming carry-save accumulator with one-cycle carry-propagate resolve.
// Build option: CSA_ACCUM_SAT_EN clamps out_data to all-ones on overflow.
module csa_accum
  import csa_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GUARD = DEF_GUARD,
  parameter int CNT_W = DEF_CNT_W,
  localparam int ACC_W = WIDTH + GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   s_q, s_d;
  logic [ACC_W-1:0]   c_q, c_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [ACC_W-1:0]   x_ext;
  logic [ACC_W-1:0]   row_sum;
  logic [ACC_W-1:0]   row_maj;
  logic [ACC_W:0]     resolved;
  logic               beat;

  assign x_ext = {{GUARD{1'b0}}, in_data};

  csa_row #(.W(ACC_W)) u_row (
    .a_in    (s_q),
    .b_in    (c_q),
    .c_in    (x_ext),
    .sum_out (row_sum),
    .maj_out (row_maj)
  );

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    beat        = in_ready_q && in_valid;
    resolved    = {1'b0, s_q} + {1'b0, c_q};

    unique case (state_q)
      ST_ACCUM: begin
        if (beat) begin
          s_d      = row_sum;
          c_d      = {row_maj[ACC_W-2:0], 1'b0};
          // The majority MSB would be shifted out of C: remember it as lost weight.
          sticky_d = sticky_q | row_maj[ACC_W-1];
          cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        out_ovf_d = sticky_q | resolved[ACC_W];
`ifdef CSA_ACCUM_SAT_EN
        out_data_d = (sticky_q | resolved[ACC_W]) ? {ACC_W{1'b1}} : resolved[ACC_W-1:0];
`else
        out_data_d = resolved[ACC_W-1:0];
`endif
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        // out_valid rises one cycle after entering OUTPUT, giving the t+2 result latency.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          s_d         = '0;
          c_d         = '0;
          sticky_d    = 1'b0;
          cnt_d       = '0;
          state_d     = ST_ACCUM;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    in_ready_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_accum.sv
// Directed and random checks of csa_accum against an arithmetic sum model.
module tb_csa_accum;

  localparam int WIDTH = 32;
  localparam int ACC_W = 36;
  localparam int CNT_W = 16;
  localparam longint unsigned ACC_MAX = 64'h0000_000F_FFFF_FFFF;
  localparam longint unsigned CNT_MAX = 64'd65535;
`ifdef CSA_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] beats[$];

  always #5 clk = ~clk;

  csa_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive the queued beats as one sum, then check latency, result and handshake.
  task automatic run_sum(input string tag, input int stall, input bit hold_valid);
    longint unsigned total = 0;
    longint unsigned exp_data, exp_cnt;
    bit exp_ovf;
    logic [ACC_W-1:0] d0;
    logic [CNT_W-1:0] c0;
    @(negedge clk);
    for (int i = 0; i < beats.size(); i++) begin
      in_valid = 1'b1;
      in_data  = beats[i];
      in_last  = (i == beats.size() - 1);
      total   += longint'(beats[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_ovf  = (total > ACC_MAX);
    exp_data = (SAT && exp_ovf) ? ACC_MAX : (total & ACC_MAX);
    exp_cnt  = (beats.size() > CNT_MAX) ? CNT_MAX : longint'(beats.size());
    @(posedge clk); #1;
    check({tag, "_valid_t1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid_t2"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), exp_data);
    check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    check({tag, "_count"}, 64'(out_count), exp_cnt);
    d0 = out_data;
    c0 = out_count;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      in_valid = hold_valid;
      in_data  = 32'h0000_0123;
      in_last  = hold_valid;
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_stall_data"}, 64'(out_data), 64'(d0));
      check({tag, "_stall_count"}, 64'(out_count), 64'(c0));
      check({tag, "_stall_inrdy"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_inrdy"}, 64'(in_ready), 64'd1);
    check({tag, "_post_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inrdy", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    beats = '{32'h0000_0005};
    run_sum("single", 0, 1'b0);

    beats = '{};
    repeat (3) beats.push_back(32'hFFFF_FFFF);
    run_sum("three_ff", 0, 1'b0);

    beats = '{};
    repeat (16) beats.push_back(32'hFFFF_FFFF);
    run_sum("sixteen_ff", 0, 1'b0);

    beats = '{};
    repeat (17) beats.push_back(32'hFFFF_FFFF);
    run_sum("seventeen_ff", 0, 1'b0);

    beats = '{};
    repeat (4) beats.push_back($urandom);
    run_sum("backpressure", 5, 1'b1);
    beats = '{32'h0000_0042};
    run_sum("after_bp", 0, 1'b0);

    // Partial sum discarded by reset
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1111_1111; in_last = 1'b0;
    @(negedge clk);
    in_data = 32'h2222_2222;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_inrdy", 64'(in_ready), 64'd1);
    check("midrst_count", 64'(out_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    beats = '{32'h0000_0007};
    run_sum("after_rst", 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 20);
      beats = '{};
      for (int i = 0; i < n; i++)
        beats.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      run_sum($sformatf("rand%0d", r), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
